// File: rtl/ptp_pkg.sv
// Shared definitions for the PTP timestamp queue: entry/beat widths, queue
// fill-level width and the read-side drain engine state encoding.
package ptp_pkg;

    localparam int PTP_ENTRY_W       = 128;
    localparam int PTP_BEAT_W        = 32;
    localparam int PTP_QUEUE_USEDW_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SEND  = 2'd2,
        FLUSH = 2'd3
    } ptp_rd_state_e;

endpackage

// File: rtl/ptp_queue_reader.sv
// Read-side drain engine for the PTP timestamp FIFO: pops one entry, waits out the
// FIFO read latency and serializes the entry MSW-first onto a valid/ready stream.
module ptp_queue_reader
    import ptp_pkg::*;
#(
    parameter int DATA_W     = PTP_ENTRY_W,
    parameter int OUT_W      = PTP_BEAT_W,
    parameter int USEDW_W    = PTP_QUEUE_USEDW_W,
    parameter int RD_LATENCY = 1
) (
    input  logic               rdclk,
    input  logic               sclr,
    input  logic [DATA_W-1:0]  fifo_q,
    input  logic               fifo_rdempty,
    input  logic [USEDW_W-1:0] fifo_rdusedw,
    output logic               fifo_rdreq,
    input  logic               flush,
    output logic [OUT_W-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_first,
    output logic               m_last,
    output logic [USEDW_W:0]   pending,
    output logic               busy
);

    localparam int BEATS  = DATA_W / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W  = $clog2(RD_LATENCY + 1);

    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0]  BEAT_ONE  = BEAT_W'(1);
    localparam logic [LAT_W-1:0]   LAT_LAST  = LAT_W'(RD_LATENCY - 1);
    localparam logic [LAT_W-1:0]   LAT_ONE   = LAT_W'(1);
    localparam logic [USEDW_W:0]   PEND_MAX  = {1'b1, {USEDW_W{1'b0}}};
    localparam logic [USEDW_W:0]   PEND_ONE  = {{USEDW_W{1'b0}}, 1'b1};
    localparam logic [USEDW_W:0]   PEND_ZERO = {(USEDW_W+1){1'b0}};

    ptp_rd_state_e     state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [USEDW_W:0]  pending_q, pending_d;
    logic [USEDW_W:0]  pend_sum_s;
    logic              rdreq_s;

    // In WAIT lat_q counts up to the data-valid cycle; in FLUSH it counts down the
    // cycles until the most recent discarded read has landed.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        rdreq_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                    lat_d   = '0;
                end else if (!fifo_rdempty) begin
                    rdreq_s = 1'b1;
                    state_d = WAIT;
                    lat_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    shift_d = fifo_q;
                    beat_d  = '0;
                    lat_d   = '0;
                    state_d = flush ? FLUSH : SEND;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end
            SEND: begin
                if (flush) begin
                    state_d = FLUSH;
                    shift_d = '0;
                    beat_d  = '0;
                    lat_d   = '0;
                end else if (m_ready) begin
                    shift_d = shift_q << OUT_W;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (!fifo_rdempty) begin
                            rdreq_s = 1'b1;
                            state_d = WAIT;
                            lat_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            FLUSH: begin
                if (!fifo_rdempty) begin
                    rdreq_s = 1'b1;
                    lat_d   = LAT_LAST;
                end else if (lat_q != '0) begin
                    lat_d = lat_q - LAT_ONE;
                end else begin
                    lat_d = '0;
                end
                if (!flush && fifo_rdempty && (lat_q == '0)) begin
                    state_d = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fill level seen by software: queued entries plus the one held in WAIT/SEND.
    always_comb begin
        pend_sum_s = {1'b0, fifo_rdusedw} +
                     (((state_q == WAIT) || (state_q == SEND)) ? PEND_ONE : PEND_ZERO);
        if (pend_sum_s > PEND_MAX) begin
            pending_d = PEND_MAX;
        end else begin
            pending_d = pend_sum_s;
        end
    end

    // State, shift register, counters and fill level.
    always_ff @(posedge rdclk) begin
        if (sclr) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            pending_q <= pending_d;
        end
    end

    assign fifo_rdreq = rdreq_s && !sclr && !fifo_rdempty;
    assign m_valid    = (state_q == SEND);
    assign m_data     = shift_q[DATA_W-1 -: OUT_W];
    assign m_first    = m_valid && (beat_q == '0);
    assign m_last     = m_valid && (beat_q == LAST_BEAT);
    assign busy       = (state_q != IDLE);
    assign pending    = pending_q;

endmodule

// File: tb/tb_ptp_queue_reader.sv
// Directed bench for ptp_queue_reader: one instance at RD_LATENCY=1 and one at
// RD_LATENCY=2, each fed by a small behavioural FIFO model.
module tb_ptp_queue_reader;

    localparam logic [127:0] E1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] E2 = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
    localparam logic [127:0] EA = 128'h1111_0001_2222_0002_3333_0003_4444_0004;
    localparam logic [127:0] EB = 128'h5555_0005_6666_0006_7777_0007_8888_0008;
    localparam logic [127:0] EC = 128'h9999_0009_AAAA_000A_BBBB_000B_CCCC_000C;
    localparam logic [127:0] EG = 128'hA5A5_0000_5A5A_1111_C3C3_2222_3C3C_3333;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sclr;
    logic flush;
    logic m_ready;

    logic [127:0] fmem [2][64];
    int           fwp [2] = '{0, 0};
    int           frp [2] = '{0, 0};
    int           pops [2] = '{0, 0};
    logic [127:0] st1 [2] = '{128'd0, 128'd0};
    logic [127:0] st2 [2] = '{128'd0, 128'd0};
    logic         f_empty [2];
    logic [3:0]   usedw [2];

    logic         rdreq_w [2];
    logic [31:0]  m_data_w [2];
    logic         m_valid_w [2];
    logic         m_first_w [2];
    logic         m_last_w [2];
    logic [4:0]   pending_w [2];
    logic         busy_w [2];

    logic [31:0]  blog [2][64];
    int           nb [2] = '{0, 0};
    int           uflow [2] = '{0, 0};
    int           stall_bad [2] = '{0, 0};
    logic         stall_q [2] = '{1'b0, 1'b0};
    logic [31:0]  hold_q [2] = '{32'd0, 32'd0};

    int n_vec = 0;
    int n_err = 0;

    ptp_queue_reader u_dut0 (
        .rdclk(clk), .sclr(sclr), .fifo_q(st1[0]), .fifo_rdempty(f_empty[0]),
        .fifo_rdusedw(usedw[0]), .fifo_rdreq(rdreq_w[0]), .flush(flush),
        .m_data(m_data_w[0]), .m_valid(m_valid_w[0]), .m_ready(m_ready),
        .m_first(m_first_w[0]), .m_last(m_last_w[0]), .pending(pending_w[0]), .busy(busy_w[0])
    );

    ptp_queue_reader #(.RD_LATENCY(2)) u_dut1 (
        .rdclk(clk), .sclr(sclr), .fifo_q(st2[1]), .fifo_rdempty(f_empty[1]),
        .fifo_rdusedw(usedw[1]), .fifo_rdreq(rdreq_w[1]), .flush(flush),
        .m_data(m_data_w[1]), .m_valid(m_valid_w[1]), .m_ready(m_ready),
        .m_first(m_first_w[1]), .m_last(m_last_w[1]), .pending(pending_w[1]), .busy(busy_w[1])
    );

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            f_empty[k] = (fwp[k] == frp[k]);
            usedw[k]   = 4'(fwp[k] - frp[k]);
        end
    end

    // FIFO read side, beat logger, underflow and stall-stability monitors.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rdreq_w[k] && !f_empty[k]) begin
                st1[k]  <= fmem[k][frp[k] % 64];
                frp[k]  <= frp[k] + 1;
                pops[k] <= pops[k] + 1;
            end
            if (rdreq_w[k] && f_empty[k]) uflow[k] <= uflow[k] + 1;
            st2[k] <= st1[k];
            if (m_valid_w[k] && m_ready) begin
                blog[k][nb[k] % 64] <= m_data_w[k];
                nb[k] <= nb[k] + 1;
            end
            if (stall_q[k] && !(m_valid_w[k] && (m_data_w[k] == hold_q[k])))
                stall_bad[k] <= stall_bad[k] + 1;
            stall_q[k] <= m_valid_w[k] && !m_ready && !flush && !sclr;
            hold_q[k]  <= m_data_w[k];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input int k, input logic [127:0] e);
        fmem[k][fwp[k] % 64] = e;
        fwp[k] = fwp[k] + 1;
    endtask

    function automatic logic [31:0] beat_of(input logic [127:0] e, input int b);
        return e[127-32*b -: 32];
    endfunction

    // One entry at m_ready=1: pop, RD_LATENCY silent cycles, four beats, back to idle.
    task automatic run_single(input int k, input logic [127:0] e, input bit do_push);
        int lat;
        lat = (k == 0) ? 1 : 2;
        if (do_push) push(k, e);
        settle();
        chk("single_rdreq", rdreq_w[k], 1);
        tick();
        for (int i = 0; i < lat; i++) begin
            chk("single_lat_novalid", m_valid_w[k], 0);
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            chk("single_valid", m_valid_w[k], 1);
            chk("single_data", m_data_w[k], beat_of(e, b));
            chk("single_first", m_first_w[k], (b == 0));
            chk("single_last", m_last_w[k], (b == 3));
            tick();
        end
        chk("single_idle_valid", m_valid_w[k], 0);
        chk("single_idle_busy", busy_w[k], 0);
    endtask

    // sclr while waiting for read data, then while presenting a beat.
    task automatic sclr_test(input int k, input logic [127:0] e);
        int lat;
        lat = (k == 0) ? 1 : 2;
        m_ready = 1'b0;
        push(k, e);
        settle();
        chk("sclr_first_rdreq", rdreq_w[k], 1);
        tick();
        sclr = 1'b1;
        settle();
        chk("sclr_wait_rdreq", rdreq_w[k], 0);
        tick();
        chk("sclr_wait_busy", busy_w[k], 0);
        chk("sclr_wait_valid", m_valid_w[k], 0);
        chk("sclr_wait_pending", pending_w[k], 0);
        push(k, ~e);
        settle();
        chk("sclr_held_rdreq", rdreq_w[k], 0);
        sclr = 1'b0;
        settle();
        chk("sclr_release_rdreq", rdreq_w[k], 1);
        tick();
        for (int i = 0; i < lat; i++) tick();
        chk("sclr_send_valid", m_valid_w[k], 1);
        chk("sclr_send_data", m_data_w[k], beat_of(~e, 0));
        sclr = 1'b1;
        tick();
        chk("sclr_send_valid_off", m_valid_w[k], 0);
        chk("sclr_send_data_zero", m_data_w[k], 0);
        chk("sclr_send_first", m_first_w[k], 0);
        chk("sclr_send_busy", busy_w[k], 0);
        chk("sclr_send_pending", pending_w[k], 0);
        sclr = 1'b0;
        settle();
        chk("sclr_after_rdreq", rdreq_w[k], 0);
        m_ready = 1'b1;
    endtask

    initial begin
        int nb_mark;
        int pop_mark;

        sclr    = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        push(0, E1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rdreq", rdreq_w[0], 0);
            chk("rst_valid", m_valid_w[0], 0);
            chk("rst_pending", pending_w[0], 0);
        end
        chk("rst_busy", busy_w[0], 0);
        chk("rst_data", m_data_w[0], 0);
        chk("rst_first_last", {m_first_w[0], m_last_w[0]}, 0);

        sclr    = 1'b0;
        m_ready = 1'b1;
        run_single(0, E1, 1'b0);
        chk("single_beat0_const", blog[0][0], 32'h0123_4567);
        chk("single_beat3_const", blog[0][3], 32'h4455_6677);

        // Backpressure: ready 1,0,0,1 across beats 0..2.
        m_ready = 1'b0;
        push(0, E2);
        settle();
        chk("bp_rdreq", rdreq_w[0], 1);
        tick();
        tick();
        chk("bp_b0", m_data_w[0], 32'hDEAD_BEEF);
        m_ready = 1'b1;
        tick();
        chk("bp_b1", m_data_w[0], 32'hCAFE_F00D);
        m_ready = 1'b0;
        tick();
        chk("bp_stall1_valid", m_valid_w[0], 1);
        chk("bp_stall1_data", m_data_w[0], 32'hCAFE_F00D);
        tick();
        chk("bp_stall2_data", m_data_w[0], 32'hCAFE_F00D);
        m_ready = 1'b1;
        tick();
        chk("bp_b2", m_data_w[0], 32'h1234_5678);
        tick();
        chk("bp_b3", m_data_w[0], 32'h9ABC_DEF0);
        chk("bp_b3_last", m_last_w[0], 1);
        tick();
        chk("bp_idle", m_valid_w[0], 0);
        chk("bp_beat_count", nb[0], 8);
        for (int i = 0; i < 4; i++) chk("bp_log", blog[0][4+i], beat_of(E2, i));

        // Three entries back to back.
        push(0, EA);
        push(0, EB);
        push(0, EC);
        settle();
        chk("b2b_rdreq0", rdreq_w[0], 1);
        tick();
        tick();
        for (int e = 0; e < 3; e++) begin
            for (int b = 0; b < 4; b++) begin
                chk("b2b_valid", m_valid_w[0], 1);
                chk("b2b_data", m_data_w[0], beat_of((e == 0) ? EA : (e == 1) ? EB : EC, b));
                if (b == 3) begin
                    chk("b2b_last_rdreq", rdreq_w[0], (e < 2));
                    chk("b2b_pending", pending_w[0], 3 - e);
                end
                tick();
            end
            if (e < 2) begin
                chk("b2b_bubble", m_valid_w[0], 0);
                tick();
            end
        end
        chk("b2b_idle", busy_w[0], 0);
        tick();
        chk("b2b_pending_end", pending_w[0], 0);
        chk("b2b_pops", pops[0], 5);
        chk("b2b_beats", nb[0], 20);

        // Flush while beat 1 is presented, five more entries queued behind it.
        for (int i = 0; i < 6; i++) push(0, {4{32'hF000_0000 + 32'(i)}});
        settle();
        chk("fl_rdreq", rdreq_w[0], 1);
        tick();
        tick();
        chk("fl_b0", m_data_w[0], 32'hF000_0000);
        tick();
        chk("fl_b1", m_data_w[0], 32'hF000_0000);
        flush   = 1'b1;
        m_ready = 1'b0;
        nb_mark  = nb[0];
        pop_mark = pops[0];
        tick();
        chk("fl_valid_drop", m_valid_w[0], 0);
        chk("fl_busy", busy_w[0], 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fl_valid_low", m_valid_w[0], 0);
        end
        flush = 1'b0;
        for (int i = 0; i < 10 && busy_w[0]; i++) tick();
        chk("fl_exit_idle", busy_w[0], 0);
        chk("fl_pops", pops[0] - pop_mark, 5);
        chk("fl_empty", f_empty[0], 1);
        chk("fl_no_beats", nb[0], nb_mark);
        m_ready = 1'b1;
        run_single(0, EG, 1'b1);

        sclr_test(0, E2);

        run_single(1, E1, 1'b1);
        sclr_test(1, EB);
        run_single(1, EG, 1'b1);

        chk("no_underflow0", uflow[0], 0);
        chk("no_underflow1", uflow[1], 0);
        chk("stall_stable0", stall_bad[0], 0);
        chk("stall_stable1", stall_bad[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
